// File: rtl/phase_accumulator_pkg.sv
// Shared constants and helpers for the multi-channel phase accumulator.
// The dither LFSR constants are used only when PHASE_DITHER_EN is defined.
package phase_accumulator_pkg;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Ceiling log2 for elaboration-time width checks; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while (r < 31 && (1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR: it advances one step on each cycle where i_en is high
// and reloads SEED on a synchronous reset.
module lfsr_galois
    import phase_accumulator_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = LFSR_POLY,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;

    // The bit shifted out of the LSB selects whether the taps are applied.
    always_comb begin
        w_next = {1'b0, r_state[WIDTH-1:1]};
        if (r_state[0]) begin
            w_next = w_next ^ POLY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/phase_accumulator_mc.sv
// Multi-channel NCO phase accumulator. Channels go out round-robin, and each output transfer
// advances that channel by its step. Optional output dither is enabled by PHASE_DITHER_EN.
module phase_accumulator_mc
    import phase_accumulator_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 4,
    parameter int DEST_WIDTH  = 2,
    parameter int DITHER_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [WIDTH-1:0]      input_phase_tdata,
    input  logic [DEST_WIDTH-1:0] input_phase_tdest,
    input  logic                  input_phase_tvalid,
    output logic                  input_phase_tready,

    input  logic [WIDTH-1:0]      input_phase_step_tdata,
    input  logic [DEST_WIDTH-1:0] input_phase_step_tdest,
    input  logic                  input_phase_step_tvalid,
    output logic                  input_phase_step_tready,

    output logic [WIDTH-1:0]      output_phase_tdata,
    output logic [DEST_WIDTH-1:0] output_phase_tdest,
    output logic                  output_phase_tlast,
    output logic                  output_phase_tvalid,
    input  logic                  output_phase_tready
);

    if (CHANNELS < 1 || DEST_WIDTH < 1 || DEST_WIDTH < clog2(CHANNELS)) begin : g_bad_dest_width
        $error("phase_accumulator_mc: DEST_WIDTH too narrow for CHANNELS");
    end

    localparam logic [DEST_WIDTH-1:0] LP_LAST_CHAN = DEST_WIDTH'(CHANNELS - 1);

    logic [WIDTH-1:0]      r_phase [CHANNELS];
    logic [WIDTH-1:0]      r_step  [CHANNELS];
    logic [DEST_WIDTH-1:0] r_chan_ptr;

    logic [WIDTH-1:0]      w_cur_phase;
    logic [WIDTH-1:0]      w_cur_step;
    logic [WIDTH-1:0]      w_sum;
    logic [CHANNELS-1:0]   w_load_hit;
    logic [CHANNELS-1:0]   w_step_hit;
    logic [CHANNELS-1:0]   w_adv_hit;
    logic [DEST_WIDTH-1:0] w_ptr_next;
    logic                  w_xfer;

    // Handshake: a beat moves on any cycle where valid and ready are both high. Every stream
    // is valid or ready on each cycle outside reset. The writes never stall, so the loads and
    // step writes complete on the same cycle they are presented.
    assign output_phase_tvalid     = !rst;
    assign input_phase_tready      = !rst;
    assign input_phase_step_tready = !rst;
    assign w_xfer                  = output_phase_tvalid & output_phase_tready;

    // A write whose tdest matches no channel (tdest >= CHANNELS) is dropped.
    always_comb begin
        w_cur_phase = '0;
        w_cur_step  = '0;
        w_load_hit  = '0;
        w_step_hit  = '0;
        w_adv_hit   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_chan_ptr == DEST_WIDTH'(c)) begin
                w_cur_phase  = r_phase[c];
                w_cur_step   = r_step[c];
                w_adv_hit[c] = w_xfer;
            end
            w_load_hit[c] = input_phase_tvalid && (input_phase_tdest == DEST_WIDTH'(c));
            w_step_hit[c] = input_phase_step_tvalid && (input_phase_step_tdest == DEST_WIDTH'(c));
        end
    end

    assign w_sum      = w_cur_phase + w_cur_step;
    assign w_ptr_next = (r_chan_ptr == LP_LAST_CHAN) ? '0 : r_chan_ptr + 1'b1;

    // A load that coincides with that channel's own advance takes priority. The advance
    // always uses the step held before any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_phase[c] <= '0;
                r_step[c]  <= '0;
            end
            r_chan_ptr <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_load_hit[c]) begin
                    r_phase[c] <= input_phase_tdata;
                end else if (w_adv_hit[c]) begin
                    r_phase[c] <= w_sum;
                end
                if (w_step_hit[c]) begin
                    r_step[c] <= input_phase_step_tdata;
                end
            end
            if (w_xfer) begin
                r_chan_ptr <= w_ptr_next;
            end
        end
    end

    assign output_phase_tdest = r_chan_ptr;
    assign output_phase_tlast = (r_chan_ptr == LP_LAST_CHAN);

`ifdef PHASE_DITHER_EN
    logic [15:0]      w_lfsr;
    logic [WIDTH-1:0] w_dither;
    logic             w_lfsr_unused;

    // The dither is added only on the output path, so the accumulators themselves stay exact.
    lfsr_galois #(
        .WIDTH (16),
        .POLY  (LFSR_POLY),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_xfer),
        .o_state (w_lfsr)
    );

    assign w_dither           = WIDTH'(w_lfsr[DITHER_BITS-1:0]);
    assign w_lfsr_unused      = ^w_lfsr;
    assign output_phase_tdata = w_cur_phase + w_dither;
`else
    assign output_phase_tdata = w_cur_phase;
`endif

endmodule

// File: tb/tb_phase_accumulator_mc.sv
// Directed bench for phase_accumulator_mc: CHANNELS=4, DEST_WIDTH=3 so out-of-range tdest can be driven.
// With PHASE_DITHER_EN defined, the expected output includes a bench-side LFSR dither.
module tb_phase_accumulator_mc;

    localparam int WIDTH       = 32;
    localparam int CHANNELS    = 4;
    localparam int DEST_WIDTH  = 3;
    localparam int DITHER_BITS = 4;

    logic                  clk;
    logic                  rst;
    logic [WIDTH-1:0]      ph_data;
    logic [DEST_WIDTH-1:0] ph_dest;
    logic                  ph_valid;
    logic                  ph_ready;
    logic [WIDTH-1:0]      st_data;
    logic [DEST_WIDTH-1:0] st_dest;
    logic                  st_valid;
    logic                  st_ready;
    logic [WIDTH-1:0]      o_data;
    logic [DEST_WIDTH-1:0] o_dest;
    logic                  o_last;
    logic                  o_valid;
    logic                  o_ready;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    logic [15:0] mdl_lfsr;

    phase_accumulator_mc #(
        .WIDTH       (WIDTH),
        .CHANNELS    (CHANNELS),
        .DEST_WIDTH  (DEST_WIDTH),
        .DITHER_BITS (DITHER_BITS)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .input_phase_tdata       (ph_data),
        .input_phase_tdest       (ph_dest),
        .input_phase_tvalid      (ph_valid),
        .input_phase_tready      (ph_ready),
        .input_phase_step_tdata  (st_data),
        .input_phase_step_tdest  (st_dest),
        .input_phase_step_tvalid (st_valid),
        .input_phase_step_tready (st_ready),
        .output_phase_tdata      (o_data),
        .output_phase_tdest      (o_dest),
        .output_phase_tlast      (o_last),
        .output_phase_tvalid     (o_valid),
        .output_phase_tready     (o_ready)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [31:0] dithered(input logic [31:0] base);
`ifdef PHASE_DITHER_EN
        return base + {28'd0, mdl_lfsr[3:0]};
`else
        return base;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: the model LFSR follows the transfers the bench expects (valid is !rst).
    task automatic tick();
        logic xfer;
        xfer = !rst && o_ready;
        @(posedge clk);
        if (rst) mdl_lfsr = 16'hACE1;
        else if (xfer) mdl_lfsr = lfsr_next(mdl_lfsr);
        @(negedge clk);
    endtask

    task automatic check_beat(input string tag, input logic [31:0] exp_data, input int exp_dest);
        #1;
        check_eq($sformatf("%s_valid", tag), 32'(o_valid), 32'd1);
        check_eq($sformatf("%s_data", tag), o_data, dithered(exp_data));
        check_eq($sformatf("%s_dest", tag), 32'(o_dest), 32'(exp_dest));
        check_eq($sformatf("%s_last", tag), 32'(o_last), (exp_dest == 3) ? 32'd1 : 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        o_ready  = 1'b1;
        ph_valid = 1'b0;
        st_valid = 1'b0;
        tick();
        #1;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_ph_ready", 32'(ph_ready), 32'd0);
        check_eq("rst_st_ready", 32'(st_ready), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic write_step(input int ch, input logic [31:0] val);
        st_dest  = DEST_WIDTH'(ch);
        st_data  = val;
        st_valid = 1'b1;
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        n_checks = 0;
        n_fail   = 0;
        mdl_lfsr = 16'hACE1;
        rst      = 1'b1;
        o_ready  = 1'b0;
        ph_data  = '0;
        ph_dest  = '0;
        ph_valid = 1'b0;
        st_data  = '0;
        st_dest  = '0;
        st_valid = 1'b0;
        @(negedge clk);

        // Test 1: after reset, zero phases, round-robin tdest, tlast on channel 3
        do_reset();
        o_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check_beat("t1", 32'd0, i % 4);
            tick();
        end

        // Test 2: a mid-stream reset restarts at channel 0, then steps 1,2,3,0x8000_0000
        do_reset();
        o_ready = 1'b0;
        write_step(0, 32'd1);
        write_step(1, 32'd2);
        write_step(2, 32'd3);
        write_step(3, 32'h8000_0000);
        exp_q = '{32'd0, 32'd0, 32'd0, 32'd0,
                  32'd1, 32'd2, 32'd3, 32'h8000_0000,
                  32'd2, 32'd4, 32'd6, 32'd0,
                  32'd3, 32'd6};
        o_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            check_beat("t2", exp_q.pop_front(), i % 4);
            tick();
        end

        // Test 3: tready toggles 0/1; each beat is held for one stall cycle; ch2 wraps at round 4
        do_reset();
        o_ready = 1'b0;
        write_step(2, 32'h4000_0000);
        for (int b = 0; b < 20; b++) begin
            e = (b % 4 == 2) ? (32'(b / 4) << 30) : 32'd0;
            o_ready = 1'b0;
            check_beat("t3_hold", e, b % 4);
            tick();
            o_ready = 1'b1;
            check_beat("t3_xfer", e, b % 4);
            tick();
        end

        // Test 4: a load during ch1's own transfer wins; a step write during a transfer uses the old step
        do_reset();
        o_ready = 1'b0;
        write_step(1, 32'h10);
        o_ready = 1'b1;
        exp_q = '{32'd0, 32'd0, 32'd0, 32'd0,
                  32'd0, 32'h1234, 32'd0, 32'd0,
                  32'd0, 32'h1244, 32'd0, 32'd0,
                  32'd0, 32'h1344};
        for (int i = 0; i < 14; i++) begin
            if (i == 1) begin
                ph_dest  = 3'd1;
                ph_data  = 32'h1234;
                ph_valid = 1'b1;
            end
            if (i == 5) begin
                st_dest  = 3'd1;
                st_data  = 32'h100;
                st_valid = 1'b1;
            end
            check_beat("t4", exp_q.pop_front(), i % 4);
            tick();
            ph_valid = 1'b0;
            st_valid = 1'b0;
        end

        // Test 5: writes with tdest 4, 5, 7 (>= CHANNELS) are ignored
        do_reset();
        o_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ph_dest  = (k == 0) ? 3'd5 : ((k == 1) ? 3'd4 : 3'd7);
            st_dest  = ph_dest;
            ph_data  = 32'hDEAD_BEEF;
            st_data  = 32'h1111;
            ph_valid = 1'b1;
            st_valid = 1'b1;
            #1;
            check_eq("t5_ph_ready", 32'(ph_ready), 32'd1);
            check_eq("t5_st_ready", 32'(st_ready), 32'd1);
            tick();
        end
        ph_valid = 1'b0;
        st_valid = 1'b0;
        o_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_beat("t5", 32'd0, i % 4);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
